// File: rtl/instr_reg_queue_if.sv
// Bundle between the instruction register/prefetch queue and its memory and control-unit clients.
// The slave modport is the IR side; master is the memory/control side driving it.
interface instr_reg_queue_if #(
  parameter int unsigned Width = 16,
  parameter int unsigned OpW   = 3,
  parameter int unsigned Depth = 4
) ();
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned DecW  = 2 ** OpW;
  localparam int unsigned AddrW = Width - OpW - 1;

  // Fetch push port
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_data;

  // Control-unit commands
  logic             ld;
  logic             clr;
  logic             inc;
  logic             flush;

  // Register contents and decoded fields
  logic [Width-1:0] q;
  logic             q_valid;
  logic             i_bit;
  logic [DecW-1:0]  d;
  logic [AddrW-1:0] addr;

  // Queue status
  logic [CntW-1:0]  count;
  logic             empty;
  logic             full;
  logic             ld_err;

  modport slave (
    input  in_valid, in_data, ld, clr, inc, flush,
    output in_ready, q, q_valid, i_bit, d, addr, count, empty, full, ld_err
  );

  modport master (
    output in_valid, in_data, ld, clr, inc, flush,
    input  in_ready, q, q_valid, i_bit, d, addr, count, empty, full, ld_err
  );
endinterface

// File: rtl/instr_reg_queue.sv
// Instruction register fed by a Depth-entry prefetch FIFO, with CLR/INC and combinational
// decode of the indirect bit, one-hot opcode and address field.
module instr_reg_queue #(
  parameter int unsigned Width = 16,
  parameter int unsigned OpW   = 3,
  parameter int unsigned Depth = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  instr_reg_queue_if.slave  bus_io
);
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned DecW  = 2 ** OpW;
  localparam int unsigned AddrW = Width - OpW - 1;

  if (Width < OpW + 2) begin : gen_bad_width
    $error("instr_reg_queue: Width must be at least OpW+2");
  end
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_bad_depth
    $error("instr_reg_queue: Depth must be a power of two >= 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             ld_err_q, ld_err_d;

  logic             empty;
  logic             full;
  logic             in_ready;
  logic             push;
  logic             pop;
  logic [DecW-1:0]  dec;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  // Full blocks the push even when a pop happens the same cycle: no push-through.
  assign in_ready = ~full & ~bus_io.flush;
  assign push     = bus_io.in_valid & in_ready;
  // No bypass: a word pushed this cycle is not yet visible to LD.
  assign pop      = bus_io.ld & ~empty & ~bus_io.clr;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus_io.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ld_err_d   = bus_io.ld & empty & ~bus_io.clr;
    if (bus_io.clr) begin
      ir_d       = '0;
      ir_valid_d = 1'b0;
    end else if (bus_io.ld) begin
      // LD outranks INC even when it faults on an empty queue.
      if (!empty) begin
        ir_d       = mem_q[rd_ptr_q];
        ir_valid_d = 1'b1;
      end
    end else if (bus_io.inc) begin
      ir_d = ir_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ld_err_q   <= ld_err_d;
    end
  end

  // Storage is not reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus_io.in_data;
    end
  end

  always_comb begin
    dec = '0;
    dec[ir_q[Width-2 -: OpW]] = 1'b1;
  end

  assign bus_io.in_ready = in_ready;
  assign bus_io.q        = ir_q;
  assign bus_io.q_valid  = ir_valid_q;
  assign bus_io.i_bit    = ir_q[Width-1];
  assign bus_io.d        = dec;
  assign bus_io.addr     = ir_q[AddrW-1:0];
  assign bus_io.count    = count_q;
  assign bus_io.empty    = empty;
  assign bus_io.full     = full;
  assign bus_io.ld_err   = ld_err_q;

endmodule

// File: tb/tb_instr_reg_queue.sv
// Directed bench for instr_reg_queue: hand-computed expectations checked with immediate assertions.
module tb_instr_reg_queue;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  instr_reg_queue_if #(.Width(16), .OpW(3), .Depth(4)) bus ();

  instr_reg_queue #(.Width(16), .OpW(3), .Depth(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply current inputs at the next rising edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ld        = 1'b0;
    bus.clr       = 1'b0;
    bus.inc       = 1'b0;
    bus.flush     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_qv", 32'(bus.q_valid), 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_d", 32'(bus.d), 32'h01);
    chk("rst_lderr", 32'(bus.ld_err), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);

    // In-order loads and field decode
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7123; tick();
    bus.in_data  = 16'h8ABC; tick();
    bus.in_data  = 16'h0FFF; tick();
    bus.in_valid = 1'b0;
    chk("fill3_count", 32'(bus.count), 32'h3);
    bus.ld = 1'b1;
    tick();
    chk("ld1_q", 32'(bus.q), 32'h7123);
    chk("ld1_qv", 32'(bus.q_valid), 32'h1);
    chk("ld1_d", 32'(bus.d), 32'h80);
    chk("ld1_i", 32'(bus.i_bit), 32'h0);
    chk("ld1_addr", 32'(bus.addr), 32'h123);
    tick();
    chk("ld2_q", 32'(bus.q), 32'h8ABC);
    chk("ld2_i", 32'(bus.i_bit), 32'h1);
    chk("ld2_d", 32'(bus.d), 32'h01);
    chk("ld2_addr", 32'(bus.addr), 32'hABC);
    tick();
    bus.ld = 1'b0;
    chk("ld3_q", 32'(bus.q), 32'h0FFF);
    chk("ld3_d", 32'(bus.d), 32'h01);
    chk("ld3_empty", 32'(bus.empty), 32'h1);

    // Full: no accept, no push-through on pop
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hA001; tick();
    bus.in_data  = 16'hA002; tick();
    bus.in_data  = 16'hA003; tick();
    bus.in_data  = 16'hA004; tick();
    chk("full_flag", 32'(bus.full), 32'h1);
    chk("full_ready", 32'(bus.in_ready), 32'h0);
    chk("full_count", 32'(bus.count), 32'h4);
    bus.in_data = 16'hA005;
    tick();
    chk("full_hold", 32'(bus.count), 32'h4);
    bus.ld = 1'b1;
    tick();
    chk("full_pop_q", 32'(bus.q), 32'hA001);
    chk("full_pop_count", 32'(bus.count), 32'h3);
    bus.ld = 1'b0;
    tick();
    chk("refill_count", 32'(bus.count), 32'h4);
    bus.in_valid = 1'b0;
    bus.ld       = 1'b1;
    tick(); chk("drain_a002", 32'(bus.q), 32'hA002);
    tick(); chk("drain_a003", 32'(bus.q), 32'hA003);
    tick(); chk("drain_a004", 32'(bus.q), 32'hA004);
    tick(); chk("drain_a005", 32'(bus.q), 32'hA005);
    chk("drain_empty", 32'(bus.empty), 32'h1);

    // LD on empty with a simultaneous push: error pulse, no bypass
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    tick();
    bus.ld       = 1'b0;
    bus.in_valid = 1'b0;
    chk("lderr_pulse", 32'(bus.ld_err), 32'h1);
    chk("lderr_q", 32'(bus.q), 32'hA005);
    chk("lderr_count", 32'(bus.count), 32'h1);
    tick();
    chk("lderr_clear", 32'(bus.ld_err), 32'h0);
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
    chk("ld_5555", 32'(bus.q), 32'h5555);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    bus.ld  = 1'b1;
    bus.clr = 1'b1;
    bus.inc = 1'b1;
    tick();
    bus.ld  = 1'b0;
    bus.clr = 1'b0;
    bus.inc = 1'b0;
    chk("clr_q", 32'(bus.q), 32'h0);
    chk("clr_qv", 32'(bus.q_valid), 32'h0);
    chk("clr_count", 32'(bus.count), 32'h1);
    chk("clr_lderr", 32'(bus.ld_err), 32'h0);
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
    chk("ld_1234", 32'(bus.q), 32'h1234);

    // INC wrap and LD-over-INC priority
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    tick();
    bus.in_valid = 1'b0;
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
    chk("ld_ffff", 32'(bus.q), 32'hFFFF);
    bus.inc = 1'b1;
    tick();
    bus.inc = 1'b0;
    chk("inc_wrap_q", 32'(bus.q), 32'h0000);
    chk("inc_wrap_qv", 32'(bus.q_valid), 32'h1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0005;
    tick();
    bus.in_valid = 1'b0;
    bus.ld  = 1'b1;
    bus.inc = 1'b1;
    tick();
    bus.ld = 1'b0;
    chk("ld_inc_q", 32'(bus.q), 32'h0005);
    tick();
    bus.inc = 1'b0;
    chk("inc_only_q", 32'(bus.q), 32'h0006);

    // FLUSH with LD and push
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1111; tick();
    bus.in_data  = 16'h2222; tick();
    bus.in_data  = 16'h3333; tick();
    chk("pre_flush_count", 32'(bus.count), 32'h3);
    bus.in_data = 16'h4444;
    bus.flush   = 1'b1;
    bus.ld      = 1'b1;
    #1;
    chk("flush_ready", 32'(bus.in_ready), 32'h0);
    tick();
    bus.flush    = 1'b0;
    bus.ld       = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_q", 32'(bus.q), 32'h1111);
    chk("flush_count", 32'(bus.count), 32'h0);
    chk("flush_empty", 32'(bus.empty), 32'h1);
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
    chk("flush_dropped", 32'(bus.ld_err), 32'h1);
    chk("flush_q_kept", 32'(bus.q), 32'h1111);

    // Asynchronous reset mid-push
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7777;
    tick();
    chk("pre_rst_count", 32'(bus.count), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.count), 32'h0);
    chk("async_rst_q", 32'(bus.q), 32'h0);
    chk("async_rst_qv", 32'(bus.q_valid), 32'h0);
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", 32'(bus.empty), 32'h1);
    chk("post_rst_d", 32'(bus.d), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
